aes_decrypt_iter: RTL

- Iterative AES-128 inverse cipher: one decryption round per clock, valid/ready handshake on both sides.
- Expands the key on the fly: forward key expansion to round key 10, then inverse key schedule stepped down to round key 0.
- Caches the last key's final round key, so back-to-back blocks under one key skip expansion.
- Optional CBC chaining. Successor to the combinational single-shot decrypter; drops into the same datapath where throughput and area matter.

---
 rtl/aes_decrypt_iter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock with on-the-fly key schedule,
// a final-round-key cache for repeated keys, and optional CBC chaining.
module aes_decrypt_iter #(
  parameter bit CBC_EN    = 1'b0,
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key_in,
  input  logic         iv_load,
  input  logic [127:0] iv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  typedef logic [0:15][7:0] blk_t;  // element 0 = byte 0 = bits [127:120]
  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND, S_DONE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i[2:0]]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward step: recover the previous w3 first, it feeds the SubWord of w0.
  function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic blk_t inv_round(input blk_t s, input blk_t rk, input logic last);
    blk_t t;
    blk_t m;
    logic [7:0] a0, a1, a2, a3;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        t[4'(4*c+r)] = INV_SBOX[s[4'(4*((c+4-r)%4)+r)]] ^ rk[4'(4*c+r)];
    m = t;
    if (!last) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = t[4'(4*c)];   a1 = t[4'(4*c+1)];
        a2 = t[4'(4*c+2)]; a3 = t[4'(4*c+3)];
        m[4'(4*c)]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        m[4'(4*c+1)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        m[4'(4*c+2)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        m[4'(4*c+3)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
    end
    return m;
  endfunction

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_ct, r_rk, r_blk, r_chain, r_plain;
  logic [127:0] r_cache_key, r_cache_rk;
  logic         r_cache_vld;

  logic [7:0]   w_rc;
  logic [127:0] w_rk_fwd, w_rk_inv, w_round;
  logic         w_accept, w_hit;

  assign w_rc     = rcon(r_cnt);
  assign w_rk_fwd = key_fwd(r_rk, w_rc);
  assign w_rk_inv = key_inv(r_rk, w_rc);
  assign w_round  = inv_round(r_blk, w_rk_inv, r_cnt == 4'd1);
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_hit    = KEY_CACHE && r_cache_vld && (key_in == r_cache_key);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign plain_out = r_plain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_hit ? S_ROUND : S_KEXP;
      S_KEXP:  if (r_cnt == 4'd10) w_state_nxt = S_ROUND;
      S_ROUND: if (r_cnt == 4'd1) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ct        <= '0;
      r_rk        <= '0;
      r_blk       <= '0;
      r_chain     <= '0;
      r_plain     <= '0;
      r_cache_key <= '0;
      r_cache_rk  <= '0;
      r_cache_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CBC_EN && iv_load) r_chain <= iv_in;
          if (w_accept) begin
            r_ct <= cipher_in;
            if (w_hit) begin
              r_rk  <= r_cache_rk;
              r_blk <= cipher_in ^ r_cache_rk;
              r_cnt <= 4'd10;
            end else begin
              // Cache key is captured now and validated when rk10 lands.
              r_rk        <= key_in;
              r_cache_key <= key_in;
              r_cache_vld <= 1'b0;
              r_cnt       <= 4'd1;
            end
          end
        end
        S_KEXP: begin
          r_rk <= w_rk_fwd;
          if (r_cnt == 4'd10) begin
            r_cache_rk  <= w_rk_fwd;
            r_cache_vld <= 1'b1;
            r_blk       <= r_ct ^ w_rk_fwd;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ROUND: begin
          r_rk  <= w_rk_inv;
          r_blk <= w_round;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_plain <= w_round ^ (CBC_EN ? r_chain : '0);
        end
        S_DONE: begin
          if (CBC_EN && out_ready) r_chain <= r_ct;
        end
        default: ;
      endcase
    end
  end

endmodule
